vga_line_block_ram: RTL and testbench
=====================================

Name: vga_line_block_ram

Overview:
- Single-clock line buffer RAM for the VGA path: 64 words x 32 bits, written a word at a time and read a byte (pixel) at a time.
- Holds one 256-pixel line of 8-bit RGB for the 256x192 screen.
- The write side is filled from main-memory read bursts by the VGA buffer controller.
- The read side is addressed by the current pixel x coordinate.

Parameters:
- WORD_AW, 6, word address width (depth = 2**WORD_AW = 64 words).
- WORD_W, 32, write word width; must be a multiple of 8.
- BYTE_AW, 8, byte read address width; must equal WORD_AW + log2(WORD_W/8).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe.
- wr_addr  in  WORD_AW  word address of write.
- wr_data  in  WORD_W  word to write.
- rd_addr  in  BYTE_AW  byte (pixel x) address to read.
- rd_data  out  8  registered byte read data.

Behaviour:
- Storage: array mem[0..63] of 32-bit words. Initial content at configuration is all zeros. Reset does not clear the array, so the block still maps onto block RAM.
- Write:
  - On a rising clk with wr_en=1, mem[wr_addr] <= wr_data.
  - With wr_en=0, the array is unchanged.
  - Writes are accepted regardless of reset.
- Byte mapping is little-endian:
  - byte address A selects word A[7:2] and lane A[1:0].
  - Lane 0 = bits 7:0, lane 1 = 15:8, lane 2 = 23:16, lane 3 = 31:24.
  - Word k therefore holds pixels 4k..4k+3, with pixel 4k in the low byte.
- Read:
  - One-cycle latency: rd_data at edge n+1 reflects rd_addr sampled at edge n.
  - rd_data is a register; there is no combinational path from rd_addr to rd_data.
- Same-word read/write collision: read-first. rd_data returns the word content before the write; the new data is visible from the next read.
- Reset:
  - While reset=1 at a rising edge, rd_data <= 0.
  - Writes still occur during reset.
  - Reset released mid-stream: the first read after release takes normal one-cycle latency.
- rd_data reset value: 0x00.
- Address wrap: all addresses are full-width, and every value is in range. There is no out-of-range case.
- No handshake and no back-pressure. The block is always ready.

Decomposition:
- Shared package: screen constants (SCREEN_WIDTH=256, SCREEN_HEIGHT=192, pixel width 8) and the line-RAM geometry constants (word count 64, word width 32).
- Optional sub-module vga_byte_lane_sel: a combinational 4:1 byte mux from a 32-bit word and a 2-bit lane index. The RAM array and the output register stay in the top module.

Test Plan:
- Basic write/read: write word 0 = 0x44332211. Reading byte addresses 0,1,2,3 returns 0x11, 0x22, 0x33, 0x44, each one cycle after the address is presented.
- Full-line fill: write word k = {4k+3, 4k+2, 4k+1, 4k} for k=0..63, then sweep rd_addr 0..255 one per cycle. rd_data equals rd_addr delayed by 1 cycle, and byte 255 returns 0xFF.
- Collision: mem[5]=0xAABBCCDD. In the same cycle write word 5 = 0x01020304 and read byte 20. rd_data = 0xDD (old value). Reading byte 20 on the next cycle returns 0x04.
- Reset:
  - After the fill, assert reset for 2 cycles while reading address 7. rd_data = 0x00 during reset.
  - On the first cycle after release with rd_addr=7, rd_data = 0x07 one cycle later; contents are preserved.
- Write during reset: with reset=1, write word 63 = 0xDEADBEEF. After release, bytes 252..255 read 0xEF, 0xBE, 0xAD, 0xDE.
- wr_en gating: with wr_en=0, drive wr_addr=0 and wr_data=0xFFFFFFFF. Byte 0 still reads its prior value.

Source files
------------

// File: rtl/vga_line_block_ram_pkg.sv
// Shared constants for the VGA line buffer.
//   Screen geometry: 256x192 pixels, 8 bits (RGB332) per pixel.
//   Line RAM geometry: 64 words x 32 bits, i.e. one full screen line.
package vga_line_block_ram_pkg;

    localparam int SCREEN_WIDTH  = 256;
    localparam int SCREEN_HEIGHT = 192;
    localparam int PIXEL_W       = 8;

    localparam int LINE_WORDS    = 64;
    localparam int LINE_WORD_W   = 32;
    localparam int LINE_WORD_AW  = $clog2(LINE_WORDS);
    localparam int LINE_BYTE_AW  = $clog2(SCREEN_WIDTH);

    // Number of pixels packed into one line-RAM word.
    localparam int PIXELS_PER_WORD = LINE_WORD_W / PIXEL_W;

    // Total pixel count of a frame, kept here so the frame-level blocks
    // share one definition with the line buffer.
    localparam int SCREEN_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;

endpackage

// File: rtl/vga_byte_lane_sel.sv
// Combinational byte-lane multiplexer.
//   word     : input word, little-endian byte lanes (lane 0 = bits 7:0)
//   lane     : lane index
//   lane_byte: selected 8-bit lane
module vga_byte_lane_sel
    import vga_line_block_ram_pkg::*;
#(
    parameter int WORD_W  = LINE_WORD_W,
    parameter int LANE_AW = $clog2(LINE_WORD_W / PIXEL_W)
) (
    input  logic [WORD_W-1:0]  word,
    input  logic [LANE_AW-1:0] lane,
    output logic [PIXEL_W-1:0] lane_byte
);

    localparam int LANES = WORD_W / PIXEL_W;

    logic [PIXEL_W-1:0] lanes [0:LANES-1];

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lanes[gi] = word[gi*PIXEL_W +: PIXEL_W];
        end
    endgenerate

    assign lane_byte = lanes[lane];

endmodule

// File: rtl/vga_line_block_ram.sv
// Line buffer RAM for the VGA path: written a word at a time from memory
// read bursts, read back one pixel (byte) at a time by pixel x coordinate.
//   clk     : clock, all logic on the rising edge
//   reset   : synchronous active-high; clears rd_data only
//   wr_en   : write strobe
//   wr_addr : word address of write
//   wr_data : word to write
//   rd_addr : byte (pixel x) address
//   rd_data : registered pixel, one cycle after rd_addr
module vga_line_block_ram
    import vga_line_block_ram_pkg::*;
#(
    parameter int WORD_AW = LINE_WORD_AW,
    parameter int WORD_W  = LINE_WORD_W,
    parameter int BYTE_AW = LINE_BYTE_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [WORD_AW-1:0] wr_addr,
    input  logic [WORD_W-1:0]  wr_data,
    input  logic [BYTE_AW-1:0] rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    localparam int DEPTH   = 2 ** WORD_AW;
    localparam int LANE_AW = BYTE_AW - WORD_AW;

    // Storage is never reset so the array stays a plain RAM.
    logic [WORD_W-1:0] mem [0:DEPTH-1];

    logic [WORD_AW-1:0] rd_word;
    logic [LANE_AW-1:0] rd_lane;
    logic [PIXEL_W-1:0] lane_byte;
    logic [PIXEL_W-1:0] rd_data_reg;

    assign rd_word = rd_addr[BYTE_AW-1:LANE_AW];
    assign rd_lane = rd_addr[LANE_AW-1:0];

    // Writes are independent of reset so a refill in progress is not lost.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    vga_byte_lane_sel #(
        .WORD_W  (WORD_W),
        .LANE_AW (LANE_AW)
    ) u_lane_sel (
        .word      (mem[rd_word]),
        .lane      (rd_lane),
        .lane_byte (lane_byte)
    );

    // The read samples the array before this edge's write lands, giving
    // read-first behaviour on a same-word collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= lane_byte;
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: tb/tb_vga_line_block_ram.sv
module tb_vga_line_block_ram;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;

    int total;
    int bad;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } exp_t;

    exp_t sb[$];

    vga_line_block_ram dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, optionally queue the expected read,
    // then sample 1 ns after the edge and compare against the queue head.
    task automatic cyc(input logic rst, input logic we, input logic [5:0] wa,
                       input logic [31:0] wd, input logic [7:0] ra,
                       input logic chk, input logic [7:0] exp, input string tag);
        exp_t e;
        reset   = rst;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = ra;
        if (chk) begin
            e.exp = exp;
            e.tag = tag;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $error("FAIL %s scoreboard empty", tag);
            end else begin
                e = sb.pop_front();
                $display("txn %s rst=%0b we=%0b ra=%0d rd_data=%02h exp=%02h",
                         e.tag, rst, we, ra, rd_data, e.exp);
                assert (rd_data === e.exp) else begin
                    bad++;
                    $error("FAIL %s got=%02h exp=%02h", e.tag, rd_data, e.exp);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

        // Reset state
        cyc(1, 0, 0, 0, 0, 1, 8'h00, "reset0");
        cyc(1, 0, 0, 0, 0, 1, 8'h00, "reset1");

        // Basic write/read
        cyc(0, 1, 0, 32'h44332211, 0, 0, 8'h00, "wr0");
        cyc(0, 0, 0, 0, 0, 1, 8'h11, "basic_b0");
        cyc(0, 0, 0, 0, 1, 1, 8'h22, "basic_b1");
        cyc(0, 0, 0, 0, 2, 1, 8'h33, "basic_b2");
        cyc(0, 0, 0, 0, 3, 1, 8'h44, "basic_b3");

        // Full-line fill, then sweep every pixel
        for (int k = 0; k < 64; k++) begin
            logic [7:0] b0;
            b0 = 8'(4 * k);
            cyc(0, 1, 6'(k), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0}, 0, 0, 8'h00, "fill");
        end
        for (int a = 0; a < 256; a++) begin
            cyc(0, 0, 0, 0, 8'(a), 1, 8'(a), $sformatf("sweep_%0d", a));
        end

        // Read-first collision on word 5
        cyc(0, 1, 5, 32'hAABBCCDD, 0, 0, 8'h00, "wr5");
        cyc(0, 1, 5, 32'h01020304, 20, 1, 8'hDD, "collide_old");
        cyc(0, 0, 0, 0, 20, 1, 8'h04, "collide_new");

        // Reset while reading, contents preserved after release
        cyc(1, 0, 0, 0, 7, 1, 8'h00, "rst_rd0");
        cyc(1, 0, 0, 0, 7, 1, 8'h00, "rst_rd1");
        cyc(0, 0, 0, 0, 7, 1, 8'h07, "rst_release");

        // Write accepted during reset
        cyc(1, 1, 63, 32'hDEADBEEF, 252, 1, 8'h00, "wr_in_rst");
        cyc(0, 0, 0, 0, 252, 1, 8'hEF, "b252");
        cyc(0, 0, 0, 0, 253, 1, 8'hBE, "b253");
        cyc(0, 0, 0, 0, 254, 1, 8'hAD, "b254");
        cyc(0, 0, 0, 0, 255, 1, 8'hDE, "b255");

        // wr_en gating: word 0 must keep {03,02,01,00}
        cyc(0, 0, 0, 32'hFFFFFFFF, 0, 1, 8'h00, "gate_same");
        cyc(0, 0, 0, 32'hFFFFFFFF, 0, 1, 8'h00, "gate_b0");
        cyc(0, 0, 0, 0, 3, 1, 8'h03, "gate_b3");
        cyc(0, 0, 0, 0, 21, 1, 8'h03, "w5_b1");

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
